// File: rtl/free_list_pkg.sv
// Shared types and constants for the physical-register free list.
// The optional retire-to-dispatch forwarding path is selected by FREE_LIST_BYPASS_EN (see free_list.sv).
package free_list_pkg;

   localparam int NUM_PR   = 64;
   localparam int NUM_ARCH = 32;
   localparam int NUM_FREE = NUM_PR - NUM_ARCH;  // must be a power of two
   localparam int NUM_ROB  = 8;

   localparam int PR_W   = $clog2(NUM_PR);
   localparam int ROB_W  = $clog2(NUM_ROB);
   localparam int SLOT_W = $clog2(NUM_FREE);
   localparam int PTR_W  = SLOT_W + 1;

   typedef logic [PR_W-1:0]  PR_IDX_t;
   typedef logic [ROB_W-1:0] ROB_IDX_t;
   typedef logic [PTR_W-1:0] FL_PTR_t;

   localparam PR_IDX_t ZERO_REG = PR_IDX_t'(31);

   typedef struct packed {
      logic     dispatch_en;
      logic     dest_valid;
      ROB_IDX_t ROB_tail_idx;
      logic     retire_en;
      PR_IDX_t  Told_idx;
      logic     rollback_en;
      ROB_IDX_t ROB_rollback_idx;
   } FREE_LIST_PACKET_IN;

   typedef struct packed {
      PR_IDX_t T_idx;
      logic    free_valid;
      FL_PTR_t free_count;
   } FREE_LIST_PACKET_OUT;

   typedef struct packed {
      FL_PTR_t head;
      FL_PTR_t tail;
   } FREE_LIST_PTRS_t;

   // Tail starts one full lap ahead of head: every non-architectural tag is free.
   localparam FREE_LIST_PTRS_t FREE_LIST_RESET = '{head: '0, tail: FL_PTR_t'(NUM_FREE)};
   localparam FL_PTR_t FREE_LIST_BACKUP_RESET  = '0;

   function automatic PR_IDX_t reset_tag(input int slot);
      return PR_IDX_t'(NUM_ARCH + slot);
   endfunction

endpackage

// File: rtl/free_list.sv
// Circular FIFO of free physical register tags with per-ROB-entry head snapshots for one-cycle rollback.
// Define FREE_LIST_BYPASS_EN to forward a retiring tag straight to dispatch when the list is empty.
module free_list
   import free_list_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              en,
   input  logic              dispatch_en,
   input  logic              dest_valid,
   input  logic [ROB_W-1:0]  ROB_tail_idx,
   input  logic              retire_en,
   input  logic [PR_W-1:0]   Told_idx,
   input  logic              rollback_en,
   input  logic [ROB_W-1:0]  ROB_rollback_idx,
   output logic [PR_W-1:0]   T_idx,
   output logic              free_valid,
   output logic [PTR_W-1:0]  free_count
);

   FREE_LIST_PACKET_IN  pkt_in;
   FREE_LIST_PACKET_OUT pkt_out;

   PR_IDX_t free_array  [NUM_FREE];
   FL_PTR_t backup_head [NUM_ROB];
   FL_PTR_t head;
   FL_PTR_t tail;

   FL_PTR_t count;
   FL_PTR_t head_next;
   PR_IDX_t head_tag;
   logic    push;
   logic    pop;
   logic    bypass;

   assign pkt_in = '{
      dispatch_en:      dispatch_en,
      dest_valid:       dest_valid,
      ROB_tail_idx:     ROB_tail_idx,
      retire_en:        retire_en,
      Told_idx:         Told_idx,
      rollback_en:      rollback_en,
      ROB_rollback_idx: ROB_rollback_idx
   };

   assign count    = tail - head;
   assign head_tag = free_array[head[SLOT_W-1:0]];
   assign push     = pkt_in.retire_en && (pkt_in.Told_idx != ZERO_REG);

`ifdef FREE_LIST_BYPASS_EN
   assign bypass = (count == '0) && push && !pkt_in.rollback_en;
`else
   assign bypass = 1'b0;
`endif

   assign pkt_out.free_valid = (count != '0) || bypass;
   assign pkt_out.T_idx      = bypass ? pkt_in.Told_idx : head_tag;
   assign pkt_out.free_count = count;

   // A rollback squashes the dispatching instruction, so it neither pops nor snapshots.
   assign pop       = pkt_in.dispatch_en && pkt_in.dest_valid && pkt_out.free_valid && !pkt_in.rollback_en;
   assign head_next = head + FL_PTR_t'(pop);

   assign T_idx      = pkt_out.T_idx;
   assign free_valid = pkt_out.free_valid;
   assign free_count = pkt_out.free_count;

   always_ff @(posedge clock) begin
      if (reset) begin
         head <= FREE_LIST_RESET.head;
         tail <= FREE_LIST_RESET.tail;
         for (int i = 0; i < NUM_FREE; i++) begin
            free_array[i] <= reset_tag(i);
         end
         for (int r = 0; r < NUM_ROB; r++) begin
            backup_head[r] <= FREE_LIST_BACKUP_RESET;
         end
      end else if (en) begin
         if (pkt_in.rollback_en) begin
            head <= backup_head[pkt_in.ROB_rollback_idx];
         end else begin
            head <= head_next;
            if (pkt_in.dispatch_en) begin
               backup_head[pkt_in.ROB_tail_idx] <= head_next;
            end
         end
         // Squashed tags between restored head and old head are never reached by tail.
         if (push) begin
            free_array[tail[SLOT_W-1:0]] <= pkt_in.Told_idx;
            tail <= tail + FL_PTR_t'(1);
         end
      end
   end

endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: directed vector table, corner-case sequences and a random ROB-driven run.
// Honours FREE_LIST_BYPASS_EN for the same-cycle forwarding expectations.
`timescale 1ns/1ps
module tb_free_list;
   import free_list_pkg::*;

   logic             clock = 1'b0;
   logic             reset, en, dispatch_en, dest_valid, retire_en, rollback_en;
   logic [ROB_W-1:0] ROB_tail_idx, ROB_rollback_idx;
   logic [PR_W-1:0]  Told_idx, T_idx;
   logic             free_valid;
   logic [PTR_W-1:0] free_count;

   int compared   = 0;
   int mismatched = 0;

   always #5 clock = ~clock;

   free_list dut (
      .clock(clock), .reset(reset), .en(en),
      .dispatch_en(dispatch_en), .dest_valid(dest_valid), .ROB_tail_idx(ROB_tail_idx),
      .retire_en(retire_en), .Told_idx(Told_idx),
      .rollback_en(rollback_en), .ROB_rollback_idx(ROB_rollback_idx),
      .T_idx(T_idx), .free_valid(free_valid), .free_count(free_count)
   );

   task automatic check(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // A valid push must never land in a full list.
   always @(posedge clock) begin
      if (!reset && en && retire_en && Told_idx != ZERO_REG) begin
         compared++;
         if (int'(free_count) >= NUM_FREE) begin
            mismatched++;
            $display("FAIL push_into_full: free_count %0d, required below %0d", free_count, NUM_FREE);
         end
      end
   end

   task automatic idle();
      reset = 1'b0; en = 1'b1;
      dispatch_en = 1'b0; dest_valid = 1'b0; ROB_tail_idx = '0;
      retire_en = 1'b0; Told_idx = '0;
      rollback_en = 1'b0; ROB_rollback_idx = '0;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      idle();
   endtask

   typedef struct {
      logic rst; logic disp; logic dest; int ts;
      logic ret; int told; logic rb; int rbs;
      int exp_t; logic exp_v; int exp_c;
   } vec_t;

   vec_t vecs[19];

   function automatic vec_t mk(input logic rst, input logic disp, input logic dest, input int ts,
                               input logic ret, input int told, input logic rb, input int rbs,
                               input int et, input logic ev, input int ec);
      vec_t v;
      v.rst = rst; v.disp = disp; v.dest = dest; v.ts = ts;
      v.ret = ret; v.told = told; v.rb = rb; v.rbs = rbs;
      v.exp_t = et; v.exp_v = ev; v.exp_c = ec;
      return v;
   endfunction

   task automatic apply_vec(input int i);
      reset = vecs[i].rst; dispatch_en = vecs[i].disp; dest_valid = vecs[i].dest;
      ROB_tail_idx = ROB_W'(vecs[i].ts);
      retire_en = vecs[i].ret; Told_idx = PR_W'(vecs[i].told);
      rollback_en = vecs[i].rb; ROB_rollback_idx = ROB_W'(vecs[i].rbs);
      tick();
      check($sformatf("vec%0d T_idx", i), int'(T_idx), vecs[i].exp_t);
      check($sformatf("vec%0d free_valid", i), int'(free_valid), int'(vecs[i].exp_v));
      check($sformatf("vec%0d free_count", i), int'(free_count), vecs[i].exp_c);
   endtask

   typedef struct { int slot; logic dest; int arch; int t; int told; } rob_e;

   int   q[$];
   int   fq[$];
   rob_e rob[$];
   int   map_t[NUM_ARCH];

   initial begin
      int   pend, t, exp_c, k, r, rob_tail;
      logic do_en, do_rb, do_ret, do_disp, do_dest;
      rob_e e;

      idle();

      //                rst  disp dest ts ret told rb  rbs  T   V   cnt
      vecs[0]  = mk(1, 0, 0, 0, 0, 0,  0, 0, 32, 1, 32);
      vecs[1]  = mk(0, 1, 1, 2, 0, 0,  0, 0, 33, 1, 31);
      vecs[2]  = mk(0, 1, 1, 3, 0, 0,  0, 0, 34, 1, 30);
      vecs[3]  = mk(0, 1, 1, 4, 0, 0,  0, 0, 35, 1, 29);
      vecs[4]  = mk(0, 0, 0, 0, 0, 0,  1, 2, 33, 1, 31);
      vecs[5]  = mk(1, 0, 0, 0, 0, 0,  0, 0, 32, 1, 32);
      vecs[6]  = mk(0, 1, 1, 0, 0, 0,  0, 0, 33, 1, 31);
      vecs[7]  = mk(0, 1, 1, 1, 0, 0,  0, 0, 34, 1, 30);
      vecs[8]  = mk(0, 1, 1, 2, 0, 0,  0, 0, 35, 1, 29);
      vecs[9]  = mk(0, 0, 0, 0, 1, 5,  0, 0, 35, 1, 30);
      vecs[10] = mk(0, 0, 0, 0, 1, 5,  0, 0, 35, 1, 31);
      vecs[11] = mk(0, 0, 0, 0, 1, 31, 0, 0, 35, 1, 31);
      vecs[12] = mk(1, 0, 0, 0, 0, 0,  0, 0, 32, 1, 32);
      vecs[13] = mk(0, 1, 1, 2, 0, 0,  0, 0, 33, 1, 31);
      vecs[14] = mk(0, 1, 1, 3, 0, 0,  0, 0, 34, 1, 30);
      vecs[15] = mk(0, 1, 1, 4, 0, 0,  0, 0, 35, 1, 29);
      vecs[16] = mk(0, 1, 0, 6, 0, 0,  0, 0, 35, 1, 29);
      vecs[17] = mk(0, 1, 1, 6, 1, 9,  1, 3, 34, 1, 31);
      vecs[18] = mk(0, 0, 0, 0, 0, 0,  1, 6, 35, 1, 30);

      for (int i = 0; i <= 11; i++) apply_vec(i);

      // Drain to empty: 29 fresh tags, then the two retired 5s.
      for (int i = 0; i < 29; i++) begin
         check("drain_a T_idx", int'(T_idx), 35 + i);
         dispatch_en = 1'b1; dest_valid = 1'b1; ROB_tail_idx = ROB_W'(i % 8);
         tick();
      end
      check("refill first T_idx", int'(T_idx), 5);
      check("refill first count", int'(free_count), 2);
      dispatch_en = 1'b1; dest_valid = 1'b1; tick();
      check("refill second T_idx", int'(T_idx), 5);
      dispatch_en = 1'b1; dest_valid = 1'b1; tick();
      check("empty count", int'(free_count), 0);
      check("empty valid", int'(free_valid), 0);
      dispatch_en = 1'b1; dest_valid = 1'b1; tick();
      check("empty dispatch count", int'(free_count), 0);
      check("empty dispatch valid", int'(free_valid), 0);

      retire_en = 1'b1; Told_idx = PR_W'(7);
      #1;
`ifdef FREE_LIST_BYPASS_EN
      check("bypass same-cycle T_idx", int'(T_idx), 7);
      check("bypass same-cycle valid", int'(free_valid), 1);
`else
      check("no-bypass same-cycle valid", int'(free_valid), 0);
`endif
      tick();
      check("retire7 T_idx", int'(T_idx), 7);
      check("retire7 valid", int'(free_valid), 1);
      check("retire7 count", int'(free_count), 1);

      dispatch_en = 1'b1; dest_valid = 1'b1; tick();
      check("pop7 count", int'(free_count), 0);
      dispatch_en = 1'b1; dest_valid = 1'b1; retire_en = 1'b1; Told_idx = PR_W'(8);
      #1;
`ifdef FREE_LIST_BYPASS_EN
      check("bypass pop T_idx", int'(T_idx), 8);
      exp_c = 0;
`else
      check("no-bypass pop valid", int'(free_valid), 0);
      exp_c = 1;
`endif
      tick();
      check("push8 count", int'(free_count), exp_c);
      check("push8 valid", int'(free_valid), exp_c);
      if (exp_c == 1) check("push8 T_idx", int'(T_idx), 8);

      en = 1'b0; dispatch_en = 1'b1; dest_valid = 1'b1; retire_en = 1'b1; Told_idx = PR_W'(12);
      tick();
      check("en low count", int'(free_count), exp_c);
      check("en low valid", int'(free_valid), exp_c);

      for (int i = 12; i <= 18; i++) apply_vec(i);
      for (int i = 0; i < 29; i++) begin
         check("drain_b T_idx", int'(T_idx), 35 + i);
         dispatch_en = 1'b1; dest_valid = 1'b1; ROB_tail_idx = ROB_W'(i % 8);
         tick();
      end
      check("tag9 present", int'(T_idx), 9);
      check("tag9 count", int'(free_count), 1);

      // Pointer wrap with paired pop/push and a reset in the middle.
      reset = 1'b1; tick();
      dispatch_en = 1'b1; dest_valid = 1'b1; tick();
      pend = 32; q.delete();
      for (int v = 33; v < 64; v++) q.push_back(v);
      for (int i = 0; i < 100; i++) begin
         if (i == 50) begin
            reset = 1'b1; dispatch_en = 1'b1; dest_valid = 1'b1; retire_en = 1'b1; Told_idx = PR_W'(pend);
            rollback_en = 1'b1; ROB_rollback_idx = ROB_W'(3);
            tick();
            check("wrap reset count", int'(free_count), 32);
            check("wrap reset T_idx", int'(T_idx), 32);
            dispatch_en = 1'b1; dest_valid = 1'b1; tick();
            pend = 32; q.delete();
            for (int v = 33; v < 64; v++) q.push_back(v);
         end
         check("wrap count", int'(free_count), 31);
         check("wrap T_idx", int'(T_idx), q[0]);
         dispatch_en = 1'b1; dest_valid = 1'b1; ROB_tail_idx = ROB_W'(i % 8);
         retire_en = 1'b1; Told_idx = PR_W'(pend);
         tick();
         t = q.pop_front(); q.push_back(pend); pend = t;
      end
      reset = 1'b1; tick();
      check("final reset count", int'(free_count), 32);
      check("final reset T_idx", int'(T_idx), 32);
      check("final reset valid", int'(free_valid), 1);

      // Random run: a small rename/ROB model drives realistic traffic.
      fq.delete(); rob.delete(); rob_tail = 0;
      for (int v = NUM_ARCH; v < NUM_PR; v++) fq.push_back(v);
      for (int a = 0; a < NUM_ARCH; a++) map_t[a] = a;
      for (int c = 0; c < 3000; c++) begin
         do_en  = ($urandom_range(0, 9) != 0);
         do_rb  = (rob.size() > 0) && ($urandom_range(0, 11) == 0);
         do_ret = (rob.size() > 0) && ($urandom_range(0, 2) == 0);
         do_disp = (rob.size() < NUM_ROB) && ($urandom_range(0, 1) == 1);
         r = $urandom_range(0, NUM_ARCH - 1);
         do_dest = (r != int'(ZERO_REG)) && (fq.size() > 0);
         k = do_rb ? $urandom_range(0, rob.size() - 1) : 0;

         en = do_en;
         dispatch_en = do_disp; dest_valid = do_dest; ROB_tail_idx = ROB_W'(rob_tail);
         retire_en = do_ret;
         Told_idx = (do_ret && rob[0].dest) ? PR_W'(rob[0].told) : ZERO_REG;
         rollback_en = do_rb;
         ROB_rollback_idx = do_rb ? ROB_W'(rob[k].slot) : '0;
         tick();

         if (do_en) begin
            if (do_rb) begin
               while (rob.size() > k + 1) begin
                  e = rob.pop_back();
                  if (e.dest) begin
                     fq.push_front(e.t);
                     map_t[e.arch] = e.told;
                  end
               end
               rob_tail = (rob[k].slot + 1) % NUM_ROB;
            end
            if (do_ret) begin
               e = rob.pop_front();
               if (e.dest) fq.push_back(e.told);
            end
            if (do_disp && !do_rb) begin
               e.slot = rob_tail; e.dest = do_dest; e.arch = r; e.t = 0; e.told = 0;
               if (do_dest) begin
                  e.t = fq.pop_front();
                  e.told = map_t[r];
                  map_t[r] = e.t;
               end
               rob.push_back(e);
               rob_tail = (rob_tail + 1) % NUM_ROB;
            end
         end

         check("rand free_count", int'(free_count), fq.size());
         check("rand free_valid", int'(free_valid), int'(fq.size() > 0));
         if (fq.size() > 0) check("rand T_idx", int'(T_idx), fq[0]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
